// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type, memory arbiter
// FSM state and requester index constants.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM-side handshake reported back to the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Arbiter FSM: ARB picks a requester, ARB_BUSY owns the RAM port.
    // The busy state carries a prefix so it does not collide with ramstate_t BUSY.
    typedef enum logic {
        ARB      = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int NREQ   = 4;
    localparam int REQ_I0 = 0;
    localparam int REQ_D0 = 1;
    localparam int REQ_I1 = 2;
    localparam int REQ_D1 = 3;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Rotating-priority picker: first set bit of req at or after ptr, wrapping.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    // Walk from the farthest slot back to ptr so the closest hit wins.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between I0, D0, I1, D1.
// One transaction in flight; one ARB bubble between grants.
// Optional macro DPRIO_EN: data requesters (odd indices) take strict
// priority over instruction requesters; round-robin within each tier.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ = cpu_types_pkg::NREQ,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][DW-1:0]  req_store,
    output logic [NREQ-1:0]          req_wait,
    output logic [DW-1:0]            req_load,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [AW-1:0]            ramaddr,
    output logic [DW-1:0]            ramstore,
    input  logic [DW-1:0]            ramload,
    input  ramstate_t                ramstate
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] active;
    logic [NREQ-1:0] data_mask;
    logic [NREQ-1:0] cand;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            g_active;
    logic [IW-1:0]   grant_inc;

    assign active   = req_ren | req_wen;
    assign req_load = ramload;
    assign g_active = active[grant_q];
    assign grant_inc = IW'((int'(grant_q) + 1) % NREQ);

    // Odd requester indices are the data ports.
    for (genvar i = 0; i < NREQ; i++) begin : g_dmask
        assign data_mask[i] = (i % 2) == 1;
    end

    // Candidate set handed to the picker; data tier masks out instruction
    // ports whenever any data port is asking.
    always_comb begin
`ifdef DPRIO_EN
        if ((active & data_mask) != '0) cand = active & data_mask;
        else                             cand = active & ~data_mask;
`else
        cand = active;
`endif
    end

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req   (cand),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Next-state: grant on any candidate; leave BUSY on completion or when
    // the granted requester withdraws (abort). Either way the pointer moves
    // past the grantee so it cannot win twice in a row under contention.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!g_active || ramstate == ACCESS) begin
                    state_d  = ARB;
                    rr_ptr_d = grant_inc;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // RAM-side and wait outputs decode straight off the grant register so a
    // withdrawn request drops its enable in the same cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        req_wait = active;
        if (state_q == ARB_BUSY) begin
            ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
            ramWEN   = req_wen[grant_q];
            ramaddr  = req_addr[grant_q];
            ramstore = req_store[grant_q];
            if (ramstate == ACCESS) req_wait[grant_q] = 1'b0;
        end
    end

    // State registers; reset abandons any transfer in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
